// File: rtl/pbtn_switch_debounce_pkg.sv
// Shared constants and helpers for the pushbutton/switch debouncer.
// Provides channel counts, debounce lengths and the counter sizing function.
`timescale 1ns/100ps
package db_pkg;
    localparam int NPB           = 6;
    localparam int NSW           = 16;
    localparam int DB_CYCLES_HW  = 500000;
    localparam int DB_CYCLES_SIM = 5;

    function automatic int db_count(input bit simulate, input int hw, input int sim);
        return simulate ? sim : hw;
    endfunction

    // Counter must hold 0..N, so clog2(N+1) bits; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/pbtn_switch_debounce_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter, registered output.
// The output follows the synchronized input only after N consecutive differing clocks.
`timescale 1ns/100ps
module db_channel
    import db_pkg::*;
#(
    parameter int N = DB_CYCLES_SIM
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            // Any cycle agreeing with the output restarts the count, so bounces never accumulate.
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/pbtn_switch_debounce.sv
// Debounces the board pushbuttons (bit 5 is the active-low CPU reset) and slide switches.
// Every input bit gets its own independent db_channel.
`timescale 1ns/100ps
module pbtn_switch_debounce #(
    parameter bit SIMULATE      = 1'b0,
    parameter int DB_CYCLES_HW  = db_pkg::DB_CYCLES_HW,
    parameter int DB_CYCLES_SIM = db_pkg::DB_CYCLES_SIM,
    parameter int NPB           = db_pkg::NPB,
    parameter int NSW           = db_pkg::NSW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NPB-1:0] pbtn_in,
    input  logic [NSW-1:0] switch_in,
    output logic [NPB-1:0] pbtn_db,
    output logic [NSW-1:0] switch_db
);
    import db_pkg::*;

    localparam int N = db_count(SIMULATE, DB_CYCLES_HW, DB_CYCLES_SIM);

    // pbtn_db[5] resets to 0, which holds the active-low downstream reset asserted.
    for (genvar i = 0; i < NPB; i++) begin : g_pb
        db_channel #(.N(N)) u_ch (
            .clk   (clk),
            .reset (reset),
            .din   (pbtn_in[i]),
            .dout  (pbtn_db[i])
        );
    end

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        db_channel #(.N(N)) u_ch (
            .clk   (clk),
            .reset (reset),
            .din   (switch_in[i]),
            .dout  (switch_db[i])
        );
    end
endmodule

// File: tb/tb_pbtn_switch_debounce.sv
// Self-checking bench for pbtn_switch_debounce with SIMULATE=1 (N=5).
// A sliding-window history model predicts every output each cycle.
`timescale 1ns/100ps
module tb_pbtn_switch_debounce;
    localparam int N   = 5;
    localparam int NPB = 6;
    localparam int NSW = 16;
    localparam int NB  = NPB + NSW;
    localparam int H   = N + 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [NPB-1:0] pbtn_in, pbtn_db;
    logic [NSW-1:0] switch_in, switch_db;

    always #5 clk = ~clk;

    pbtn_switch_debounce #(
        .SIMULATE      (1'b1),
        .DB_CYCLES_HW  (500000),
        .DB_CYCLES_SIM (N),
        .NPB           (NPB),
        .NSW           (NSW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pbtn_in   (pbtn_in),
        .switch_in (switch_in),
        .pbtn_db   (pbtn_db),
        .switch_db (switch_db)
    );

    int total = 0;
    int bad   = 0;

    // hist[k] = input vector sampled k edges ago; mout = predicted outputs.
    logic [NB-1:0] hist [H];
    logic [NB-1:0] mout;

    typedef struct {
        logic [NPB-1:0] pb;
        logic [NSW-1:0] sw;
        int             hold;
        logic [NPB-1:0] epb;
        logic [NSW-1:0] esw;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // A bit flips when the synchronized value (sampled 2 edges back) has been one
    // constant value differing from the output for the last N samples.
    task automatic model_edge();
        logic run;
        if (reset) begin
            for (int k = 0; k < H; k++) hist[k] = '0;
            mout = '0;
        end else begin
            for (int k = H - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {pbtn_in, switch_in};
            for (int b = 0; b < NB; b++) begin
                run = 1'b1;
                for (int k = 3; k <= N + 1; k++)
                    if (hist[k][b] !== hist[2][b]) run = 1'b0;
                if (run && hist[2][b] !== mout[b]) mout[b] = hist[2][b];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_pb", 32'(pbtn_db), 32'(mout[NB-1:NSW]));
        chk("model_sw", 32'(switch_db), 32'(mout[NSW-1:0]));
    endtask

    task automatic seq_check(input logic [NSW-1:0] val, input logic [NSW-1:0] prev, input string nm);
        switch_in = val;
        for (int e = 0; e < 100; e++) begin
            step();
            if (e == 5) chk({nm, "_edge5"}, 32'(switch_db), 32'(prev));
            if (e == 6) chk({nm, "_edge6"}, 32'(switch_db), 32'(val));
        end
    endtask

    vec_t tbl [8];

    initial begin
        int trans, tedge, glitches, hold;
        logic prev3;

        for (int k = 0; k < H; k++) hist[k] = '0;
        mout      = '0;
        reset     = 1'b1;
        pbtn_in   = '0;
        switch_in = 16'habcd;

        // Reset held with switches set; outputs stay 0, then appear at edge N+1.
        repeat (100) step();
        chk("rst_pb", 32'(pbtn_db), 32'h0);
        chk("rst_sw", 32'(switch_db), 32'h0);
        reset = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            step();
            if (e == 5) chk("rel_edge5_sw", 32'(switch_db), 32'h0);
            if (e == 6) chk("rel_edge6_sw", 32'(switch_db), 32'habcd);
        end
        switch_in = '0;
        repeat (10) step();

        tbl[0] = '{6'h01,      16'h0000, 3, 6'h00,      16'h0000};
        tbl[1] = '{6'h00,      16'h0000, 8, 6'h00,      16'h0000};
        tbl[2] = '{6'b100111,  16'h0000, 6, 6'h00,      16'h0000};
        tbl[3] = '{6'b100111,  16'h0000, 1, 6'b100111,  16'h0000};
        tbl[4] = '{6'b100111,  16'h1234, 7, 6'b100111,  16'h1234};
        tbl[5] = '{6'b100111,  16'h5678, 4, 6'b100111,  16'h1234};
        tbl[6] = '{6'b100111,  16'h1234, 8, 6'b100111,  16'h1234};
        tbl[7] = '{6'h00,      16'hffff, 7, 6'h00,      16'hffff};
        for (int i = 0; i < 8; i++) begin
            pbtn_in   = tbl[i].pb;
            switch_in = tbl[i].sw;
            repeat (tbl[i].hold) step();
            chk($sformatf("tbl%0d_pb", i), 32'(pbtn_db), 32'(tbl[i].epb));
            chk($sformatf("tbl%0d_sw", i), 32'(switch_db), 32'(tbl[i].esw));
        end

        // Bouncing switch: exactly one rising transition, 6 edges after settling.
        switch_in = '0;
        repeat (10) step();
        trans = 0;
        tedge = -1;
        prev3 = switch_db[3];
        for (int c = 0; c < 20; c++) begin
            switch_in[3] = ((c / 2) % 2) == 0;
            step();
            if (switch_db[3] !== prev3) trans++;
            prev3 = switch_db[3];
        end
        switch_in[3] = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            if (switch_db[3] !== prev3) begin
                trans++;
                tedge = e;
            end
            prev3 = switch_db[3];
        end
        chk("bounce_trans", 32'(trans), 32'd1);
        chk("bounce_edge", 32'(tedge), 32'd6);
        chk("bounce_val", 32'(switch_db[3]), 32'd1);

        // Reset mid-count discards progress; outputs clear asynchronously.
        pbtn_in   = 6'b100111;
        switch_in = 16'hffff;
        repeat (10) step();
        switch_in = 16'h1234;
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pb", 32'(pbtn_db), 32'h0);
        chk("async_rst_sw", 32'(switch_db), 32'h0);
        repeat (2) step();
        reset = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            step();
            if (e == 5) begin
                chk("rst2_edge5_sw", 32'(switch_db), 32'h0);
                chk("rst2_edge5_pb", 32'(pbtn_db), 32'h0);
            end
            if (e == 6) begin
                chk("rst2_edge6_sw", 32'(switch_db), 32'h1234);
                chk("rst2_edge6_pb", 32'(pbtn_db), 32'(6'b100111));
            end
        end

        // Value sequence; upper bit of each pair must stay 1 across ffff -> aaaa.
        seq_check(16'h0011, 16'h1234, "seq0011");
        seq_check(16'hffff, 16'h0011, "seqffff");
        switch_in = 16'haaaa;
        glitches  = 0;
        for (int e = 0; e < 100; e++) begin
            step();
            if ((switch_db & 16'haaaa) !== 16'haaaa) glitches++;
            if (e == 5) chk("seqaaaa_edge5", 32'(switch_db), 32'hffff);
            if (e == 6) chk("seqaaaa_edge6", 32'(switch_db), 32'haaaa);
        end
        chk("seqaaaa_glitch", 32'(glitches), 32'd0);

        // Randomized stimulus with varying hold lengths and occasional resets.
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    pbtn_in   = NPB'($urandom);
                    switch_in = NSW'($urandom);
                end else begin
                    int b;
                    b = $urandom_range(0, NB - 1);
                    if (b < NSW) switch_in[b] = ~switch_in[b];
                    else         pbtn_in[b - NSW] = ~pbtn_in[b - NSW];
                end
                hold = $urandom_range(1, 9);
            end
            hold--;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
